// File: rtl/ci_stim_pkg.sv
// ci_stim_pkg
// Shared definitions for the CI biphasic stimulus controller:
//   - stim_state_t : FSM state encoding (STOP, ANO, GAP1, CAT, GAP2, IDLE)
//   - stim_out_t   : bundle of every registered output of the controller
//   - DEF_TICK_DIV / DEF_W_CFG : default parameter values
//   - out_for()    : output pattern belonging to each state
package ci_stim_pkg;

  localparam int DEF_TICK_DIV = 100;
  localparam int DEF_W_CFG    = 4;

  typedef enum logic [2:0] {
    ST_STOP = 3'd0,
    ST_ANO  = 3'd1,
    ST_GAP1 = 3'd2,
    ST_CAT  = 3'd3,
    ST_GAP2 = 3'd4,
    ST_IDLE = 3'd5
  } stim_state_t;

  typedef struct packed {
    logic ano_top;
    logic ano_bot;
    logic cat_top;
    logic cat_bot;
    logic curr_ena;
    logic led_r;
    logic led_g;
    logic led_b;
  } stim_out_t;

  // Every output is a pure function of the state being entered, so the
  // FSM loads the output register with this pattern on each transition.
  // Only one diagonal of the H-bridge is ever closed, and the gap states
  // open all four switches while the current source stays enabled.
  function automatic stim_out_t out_for(stim_state_t s);
    stim_out_t o;
    o = '0;
    case (s)
      ST_STOP: o.led_r = 1'b1;
      ST_ANO: begin
        o.ano_top  = 1'b1;
        o.cat_bot  = 1'b1;
        o.curr_ena = 1'b1;
        o.led_g    = 1'b1;
        o.led_b    = 1'b1;
      end
      ST_CAT: begin
        o.cat_top  = 1'b1;
        o.ano_bot  = 1'b1;
        o.curr_ena = 1'b1;
        o.led_g    = 1'b1;
        o.led_b    = 1'b1;
      end
      ST_GAP1, ST_GAP2: begin
        o.curr_ena = 1'b1;
        o.led_g    = 1'b1;
      end
      ST_IDLE: o.led_g = 1'b1;
      default: o.led_r = 1'b1;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/btn_sync_edge.sv
// btn_sync_edge
// Brings an asynchronous push-button into the clock domain through a
// 2-FF synchronizer and emits a registered one-clock pulse on each rising
// edge. A level held high produces a single pulse.
// Ports:
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   btn   : raw button level, asynchronous to clk
//   rise  : one-clock pulse, two clocks after the synchronized rising edge
module btn_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic rise
);

  logic sync_1;
  logic sync_2;
  logic sync_3;

  // The whole chain resets to 1 so that a button already held high when
  // reset is released looks like a steady level rather than a fresh edge;
  // only a real low-to-high transition afterwards produces a pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_1 <= 1'b1;
      sync_2 <= 1'b1;
      sync_3 <= 1'b1;
      rise   <= 1'b0;
    end else begin
      sync_1 <= btn;
      sync_2 <= sync_1;
      sync_3 <= sync_2;
      rise   <= sync_2 & ~sync_3;
    end
  end

endmodule

// File: rtl/ci_stim_wrapper.sv
// ci_stim_wrapper
// Biphasic, charge-balanced current-stimulus controller. Each pulse is
// anodic phase, 1-clock dead gap, cathodic phase, 1-clock dead gap, then
// an idle interval, repeated until stopped.
// Parameters:
//   TICK_DIV : clocks per timing tick (must be >= 2)
//   W_CFG    : width of i_duty / i_idle
// Ports:
//   i_clk, i_rst_n          : clock, asynchronous active-low reset
//   i_start_btn, i_stop_btn : asynchronous push buttons, active-high
//   i_duty, i_idle          : phase width / idle interval in ticks (0 -> 1)
//   o_ano_top .. o_cat_bot  : H-bridge gate drives, active-high
//   o_curr_ena              : current-source enable
//   o_led_r/g/b             : status LED (r stopped, g running, b phase)
module ci_stim_wrapper
  import ci_stim_pkg::*;
#(
  parameter int TICK_DIV = DEF_TICK_DIV,
  parameter int W_CFG    = DEF_W_CFG
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start_btn,
  input  logic             i_stop_btn,
  input  logic [W_CFG-1:0] i_duty,
  input  logic [W_CFG-1:0] i_idle,
  output logic             o_ano_top,
  output logic             o_ano_bot,
  output logic             o_cat_top,
  output logic             o_cat_bot,
  output logic             o_curr_ena,
  output logic             o_led_r,
  output logic             o_led_g,
  output logic             o_led_b
);

  localparam int PRE_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

  logic             start_evt;
  logic             stop_evt;
  stim_state_t      state;
  stim_state_t      phase_next;
  stim_out_t        outs;
  logic [PRE_W-1:0] pre_cnt;
  logic [W_CFG-1:0] tick_cnt;
  logic [W_CFG-1:0] duty_q;
  logic [W_CFG-1:0] idle_q;
  logic [W_CFG-1:0] duty_eff;
  logic [W_CFG-1:0] idle_eff;
  logic [W_CFG-1:0] phase_last;

  btn_sync_edge u_start_sync (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .btn   (i_start_btn),
    .rise  (start_evt)
  );

  btn_sync_edge u_stop_sync (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .btn   (i_stop_btn),
    .rise  (stop_evt)
  );

  // A zero setting would mean an empty phase; it is promoted to one tick.
  assign duty_eff = (i_duty == '0) ? W_CFG'(1) : i_duty;
  assign idle_eff = (i_idle == '0) ? W_CFG'(1) : i_idle;

  // Which latched length governs the current tick-timed phase, and which
  // state follows once that phase has run its full length.
  always_comb begin
    phase_last = duty_q - W_CFG'(1);
    phase_next = ST_GAP1;
    case (state)
      ST_ANO:  phase_next = ST_GAP1;
      ST_CAT:  phase_next = ST_GAP2;
      ST_IDLE: begin
        phase_last = idle_q - W_CFG'(1);
        phase_next = ST_ANO;
      end
      default: phase_next = ST_GAP1;
    endcase
  end

  // Pulse sequencer. The prescaler and tick counter restart at every state
  // entry, so a phase of N ticks lasts exactly N*TICK_DIV clocks. Duty and
  // idle are sampled only when a pulse starts, so the pulse in progress is
  // never reshaped by a configuration change. A stop event beats everything
  // else, including a start arriving in the same cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= ST_STOP;
      outs     <= out_for(ST_STOP);
      pre_cnt  <= '0;
      tick_cnt <= '0;
      duty_q   <= W_CFG'(1);
      idle_q   <= W_CFG'(1);
    end else if (state != ST_STOP && stop_evt) begin
      state    <= ST_STOP;
      outs     <= out_for(ST_STOP);
      pre_cnt  <= '0;
      tick_cnt <= '0;
    end else begin
      case (state)
        ST_STOP: begin
          if (start_evt && !stop_evt) begin
            state    <= ST_ANO;
            outs     <= out_for(ST_ANO);
            duty_q   <= duty_eff;
            idle_q   <= idle_eff;
            pre_cnt  <= '0;
            tick_cnt <= '0;
          end
        end
        ST_ANO, ST_CAT, ST_IDLE: begin
          if (pre_cnt == PRE_LAST) begin
            pre_cnt <= '0;
            if (tick_cnt == phase_last) begin
              tick_cnt <= '0;
              state    <= phase_next;
              outs     <= out_for(phase_next);
              if (state == ST_IDLE) begin
                duty_q <= duty_eff;
                idle_q <= idle_eff;
              end
            end else begin
              tick_cnt <= tick_cnt + W_CFG'(1);
            end
          end else begin
            pre_cnt <= pre_cnt + PRE_W'(1);
          end
        end
        ST_GAP1: begin
          state    <= ST_CAT;
          outs     <= out_for(ST_CAT);
          pre_cnt  <= '0;
          tick_cnt <= '0;
        end
        ST_GAP2: begin
          state    <= ST_IDLE;
          outs     <= out_for(ST_IDLE);
          pre_cnt  <= '0;
          tick_cnt <= '0;
        end
        default: begin
          state    <= ST_STOP;
          outs     <= out_for(ST_STOP);
          pre_cnt  <= '0;
          tick_cnt <= '0;
        end
      endcase
    end
  end

  assign o_ano_top  = outs.ano_top;
  assign o_ano_bot  = outs.ano_bot;
  assign o_cat_top  = outs.cat_top;
  assign o_cat_bot  = outs.cat_bot;
  assign o_curr_ena = outs.curr_ena;
  assign o_led_r    = outs.led_r;
  assign o_led_g    = outs.led_g;
  assign o_led_b    = outs.led_b;

endmodule

// File: tb/tb_ci_stim_wrapper.sv
// tb_ci_stim_wrapper
// Self-checking bench for ci_stim_wrapper (TICK_DIV=4, W_CFG=4). A
// reference model predicts every output from the pulse rules: position
// within the pulse period, button edges delayed by the three-clock
// latency, and configuration sampled at each pulse start.
module tb_ci_stim_wrapper;

  localparam int TICK = 4;
  localparam int W    = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         start_btn = 1'b0;
  logic         stop_btn = 1'b0;
  logic [W-1:0] duty = 4'd7;
  logic [W-1:0] idle = 4'd7;
  logic         o_ano_top, o_ano_bot, o_cat_top, o_cat_bot;
  logic         o_curr_ena, o_led_r, o_led_g, o_led_b;
  logic [7:0]   outVec;

  int cmpCount = 0;
  int errCount = 0;
  int cyc = 0;

  // Reference model state
  bit         mRun = 1'b0;
  int         mPos = 0;
  int         mD = 1;
  int         mI = 1;
  bit         mPrevStart = 1'b1;
  bit         mPrevStop = 1'b1;
  bit [2:0]   mStartPipe = 3'b000;
  bit [2:0]   mStopPipe = 3'b000;
  logic [7:0] expOut = 8'h04;

  ci_stim_wrapper #(.TICK_DIV(TICK), .W_CFG(W)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_start_btn (start_btn),
    .i_stop_btn  (stop_btn),
    .i_duty      (duty),
    .i_idle      (idle),
    .o_ano_top   (o_ano_top),
    .o_ano_bot   (o_ano_bot),
    .o_cat_top   (o_cat_top),
    .o_cat_bot   (o_cat_bot),
    .o_curr_ena  (o_curr_ena),
    .o_led_r     (o_led_r),
    .o_led_g     (o_led_g),
    .o_led_b     (o_led_b)
  );

  assign outVec = {o_ano_top, o_ano_bot, o_cat_top, o_cat_bot,
                   o_curr_ena, o_led_r, o_led_g, o_led_b};

  // 300 ns clock
  initial forever #150 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  function automatic int effOf(logic [W-1:0] v);
    return (v == '0) ? 1 : int'(v);
  endfunction

  function automatic int periodOf(int d, int i);
    return 2 * d * TICK + 2 + i * TICK;
  endfunction

  // Output pattern from position inside the pulse:
  // [0,DT) anodic, DT gap, (DT,2DT] cathodic, 2DT+1 gap, rest idle.
  function automatic logic [7:0] expectedOut(bit run, int pos, int d);
    int ph;
    ph = d * TICK;
    if (!run)            return 8'b0000_0100;
    if (pos < ph)        return 8'b1001_1011;
    if (pos == ph)       return 8'b0000_1010;
    if (pos <= 2 * ph)   return 8'b0110_1011;
    if (pos == 2*ph + 1) return 8'b0000_1010;
    return 8'b0000_0010;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    cmpCount++;
    if (obs !== exp) begin
      errCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Reference model: button edges at sample k act on the state at k+3.
  initial begin
    bit stEv;
    bit spEv;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        mRun = 1'b0;
        mPos = 0;
        mPrevStart = 1'b1;
        mPrevStop = 1'b1;
        mStartPipe = 3'b000;
        mStopPipe = 3'b000;
      end else begin
        stEv = mStartPipe[2];
        spEv = mStopPipe[2];
        mStartPipe = {mStartPipe[1:0], start_btn & ~mPrevStart};
        mStopPipe = {mStopPipe[1:0], stop_btn & ~mPrevStop};
        mPrevStart = start_btn;
        mPrevStop = stop_btn;
        if (!mRun) begin
          if (stEv && !spEv) begin
            mRun = 1'b1;
            mPos = 0;
            mD = effOf(duty);
            mI = effOf(idle);
          end
        end else if (spEv) begin
          mRun = 1'b0;
        end else begin
          mPos++;
          if (mPos == periodOf(mD, mI)) begin
            mPos = 0;
            mD = effOf(duty);
            mI = effOf(idle);
          end
        end
      end
      expOut = expectedOut(mRun, mPos, mD);
    end
  end

  // Every-cycle comparison against the model plus the bridge safety rules
  initial forever begin
    @(negedge clk);
    checkOutput("cycle_outputs", 32'(outVec), 32'(expOut));
    checkOutput("inv_ano_leg", 32'(o_ano_top & o_ano_bot), 32'd0);
    checkOutput("inv_cat_leg", 32'(o_cat_top & o_cat_bot), 32'd0);
    checkOutput("inv_both_tops", 32'(o_ano_top & o_cat_top), 32'd0);
  end

  task automatic applyStimulus(input logic st, input logic sp);
    start_btn = st;
    stop_btn = sp;
    @(negedge clk);
  endtask

  // Waits (bounded) for ano_top (which=0) or cat_top (which=1) to reach level
  task automatic waitSig(input string tag, input int which, input logic level,
                         input int budget, output int at);
    logic v;
    v = ~level;
    at = -1;
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      v = (which == 0) ? o_ano_top : o_cat_top;
      if (v == level) begin
        at = cyc;
        break;
      end
    end
    checkOutput(tag, 32'(v), 32'(level));
  endtask

  task automatic pressStart(output int lat, output int riseAt);
    int k;
    k = cyc + 1;
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0);
    waitSig("wait_start_ano", 0, 1'b1, 20, riseAt);
    lat = riseAt - k;
  endtask

  initial begin
    int lat, tRise, tFall, tNext, tc, tcf, ta, taf;

    // Reset and quiet idle
    #1 rst_n = 1'b0;
    #50 checkOutput("reset_values", 32'(outVec), 32'h04);
    #50 rst_n = 1'b1;
    repeat (10000) @(negedge clk);
    checkOutput("idle_no_switching", 32'(outVec[7:3]), 32'd0);

    // Nominal run: duty 7, idle 7
    pressStart(lat, tRise);
    checkOutput("start_latency", 32'(lat), 32'd3);
    waitSig("wait_ano_fall", 0, 1'b0, 100, tFall);
    checkOutput("ano_length", 32'(tFall - tRise), 32'd28);
    waitSig("wait_ano_next", 0, 1'b1, 200, tNext);
    checkOutput("period_7_7", 32'(tNext - tRise), 32'd86);

    // Stop mid-CAT with start pressed in the same cycle
    waitSig("wait_cat", 1, 1'b1, 200, tc);
    applyStimulus(1'b1, 1'b1);
    applyStimulus(1'b0, 1'b0);
    repeat (2) @(negedge clk);
    checkOutput("stop_outputs", 32'(outVec), 32'h04);
    repeat (20) @(negedge clk);
    checkOutput("stay_stopped", 32'(outVec), 32'h04);

    // Fresh start, then change duty during CAT
    pressStart(lat, tRise);
    checkOutput("restart_latency", 32'(lat), 32'd3);
    waitSig("wait_cat_cfg", 1, 1'b1, 200, tc);
    duty = 4'd2;
    waitSig("wait_cat_fall", 1, 1'b0, 100, tcf);
    checkOutput("cat_length_kept", 32'(tcf - tc), 32'd28);
    waitSig("wait_ano_cfg", 0, 1'b1, 200, ta);
    waitSig("wait_ano_cfg_fall", 0, 1'b0, 100, taf);
    checkOutput("new_ano_length", 32'(taf - ta), 32'd8);

    // Zero configuration
    applyStimulus(1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0);
    repeat (4) @(negedge clk);
    duty = 4'd0;
    idle = 4'd0;
    pressStart(lat, tRise);
    waitSig("wait_zero_fall", 0, 1'b0, 50, tFall);
    checkOutput("zero_ano_length", 32'(tFall - tRise), 32'd4);
    waitSig("wait_zero_next", 0, 1'b1, 50, tNext);
    checkOutput("zero_period", 32'(tNext - tRise), 32'd14);

    // Asynchronous reset mid-run with start held through release
    start_btn = 1'b1;
    @(negedge clk);
    #40 rst_n = 1'b0;
    #1 checkOutput("async_reset", 32'(outVec), 32'h04);
    repeat (2) @(negedge clk);
    #40 rst_n = 1'b1;
    repeat (20) @(negedge clk);
    checkOutput("held_button_no_start", 32'(outVec), 32'h04);
    start_btn = 1'b0;

    // About 1 ms of random buttons and configuration
    duty = 4'd3;
    idle = 4'd2;
    for (int n = 0; n < 3400; n++) begin
      start_btn = ($urandom_range(0, 59) == 0);
      stop_btn = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 99) == 0) begin
        duty = 4'($urandom_range(0, 15));
        idle = 4'($urandom_range(0, 15));
      end
      @(negedge clk);
    end
    start_btn = 1'b0;
    stop_btn = 1'b0;
    repeat (10) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCount, errCount);
    $finish;
  end

endmodule
